// File: rtl/rvc_fetch_aligner_if.sv
// Fetch/instruction handshake bundle for rvc_fetch_aligner.
//   master : the aligner (drives fetch address/ready and the instruction slot)
//   slave  : the surrounding fetch stage and rvc_expander
interface rvc_fetch_aligner_if;
  logic [31:0] fetch_addr_o;
  logic        fetch_valid_i;
  logic [31:0] fetch_word_i;
  logic        fetch_ready_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_ready_i;

  modport master (
    output fetch_addr_o, fetch_ready_o,
    output instr_valid_o, instr_o, instr_pc_o, instr_compressed_o,
    input  fetch_valid_i, fetch_word_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  fetch_addr_o, fetch_ready_o,
    input  instr_valid_o, instr_o, instr_pc_o, instr_compressed_o,
    output fetch_valid_i, fetch_word_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// Splits word-aligned 32-bit fetch words into 16-bit (zero-extended) and
// 32-bit instructions, including 32-bit instructions straddling two words.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-low
//   bus    - master side of rvc_fetch_aligner_if: fetch address/word
//            handshake, redirect, and the single-entry instruction slot
module rvc_fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic                  clk_i,
  input logic                  rst_i,
  rvc_fetch_aligner_if.master  bus
);

  typedef enum logic [1:0] {
    S_ALIGNED = 2'd0,  // nothing buffered
    S_HALF    = 2'd1,  // hb_q holds the first halfword of the next instruction
    S_SKIP    = 2'd2   // started mid-word: drop the low halfword of the next word
  } state_e;

  localparam state_e BOOT_STATE = BOOT_ADDR[1] ? S_SKIP : S_ALIGNED;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] faddr_q, faddr_d;
  logic [15:0] hb_q, hb_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_c_q, instr_c_d;

  logic        slot_free_c;
  logic        hb_is32_c;
  logic        lo_is32_c;
  logic        fetch_ready_c;
  logic        accept_c;
  logic [15:0] lo_c, hi_c;

  // Handshake qualifiers; a redirect blocks word consumption in its cycle.
  always_comb begin
    slot_free_c   = !instr_valid_q || bus.instr_ready_i;
    hb_is32_c     = (hb_q[1:0] == 2'b11);
    lo_c          = bus.fetch_word_i[15:0];
    hi_c          = bus.fetch_word_i[31:16];
    lo_is32_c     = (lo_c[1:0] == 2'b11);
    fetch_ready_c = 1'b0;
    if (!bus.redirect_i) begin
      case (state_q)
        S_ALIGNED: fetch_ready_c = slot_free_c;
        S_HALF:    fetch_ready_c = hb_is32_c && slot_free_c;
        S_SKIP:    fetch_ready_c = 1'b1;
        default:   fetch_ready_c = 1'b0;
      endcase
    end
    accept_c = bus.fetch_valid_i && fetch_ready_c;
  end

  // Next-state and output-slot logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    faddr_d       = faddr_q;
    hb_d          = hb_q;
    instr_valid_d = instr_valid_q && !bus.instr_ready_i;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_c_d     = instr_c_q;

    if (bus.redirect_i) begin
      pc_d          = bus.redirect_pc_i & 32'hFFFF_FFFE;
      faddr_d       = bus.redirect_pc_i & 32'hFFFF_FFFC;
      hb_d          = 16'h0000;
      instr_valid_d = 1'b0;
      state_d       = bus.redirect_pc_i[1] ? S_SKIP : S_ALIGNED;
    end else begin
      if (accept_c) begin
        faddr_d = faddr_q + 32'd4;
      end
      case (state_q)
        S_ALIGNED: begin
          if (accept_c) begin
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
            if (lo_is32_c) begin
              instr_d   = bus.fetch_word_i;
              instr_c_d = 1'b0;
              pc_d      = pc_q + 32'd4;
            end else begin
              instr_d   = {16'h0000, lo_c};
              instr_c_d = 1'b1;
              hb_d      = hi_c;
              pc_d      = pc_q + 32'd2;
              state_d   = S_HALF;
            end
          end
        end
        S_HALF: begin
          if (!hb_is32_c) begin
            // Buffered compressed instruction drains without a new word.
            if (slot_free_c) begin
              instr_valid_d = 1'b1;
              instr_pc_d    = pc_q;
              instr_d       = {16'h0000, hb_q};
              instr_c_d     = 1'b1;
              pc_d          = pc_q + 32'd2;
              state_d       = S_ALIGNED;
            end
          end else if (accept_c) begin
            // Straddling instruction: low half of the new word completes it.
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
            instr_d       = {lo_c, hb_q};
            instr_c_d     = 1'b0;
            pc_d          = pc_q + 32'd4;
            hb_d          = hi_c;
          end
        end
        S_SKIP: begin
          if (accept_c) begin
            hb_d    = hi_c;
            state_d = S_HALF;
          end
        end
        default: state_d = S_ALIGNED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= BOOT_STATE;
      pc_q          <= BOOT_ADDR & 32'hFFFF_FFFE;
      faddr_q       <= BOOT_ADDR & 32'hFFFF_FFFC;
      hb_q          <= 16'h0000;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_c_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      faddr_q       <= faddr_d;
      hb_q          <= hb_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_c_q     <= instr_c_d;
    end
  end

  assign bus.fetch_addr_o       = faddr_q;
  assign bus.fetch_ready_o      = fetch_ready_c;
  assign bus.instr_valid_o      = instr_valid_q;
  assign bus.instr_o            = instr_q;
  assign bus.instr_pc_o         = instr_pc_q;
  assign bus.instr_compressed_o = instr_c_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Self-checking bench for rvc_fetch_aligner: directed scenarios followed by
// randomized traffic checked against a memory-based instruction-stream model.
module tb_rvc_fetch_aligner;

  logic clk;
  logic rst_n;

  rvc_fetch_aligner_if bus ();

  rvc_fetch_aligner #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;

  // Memory seen by the fetch stage; words are created lazily on first read.
  logic [31:0] mem [logic [31:0]];

  // Reference state: next instruction PC to hand over, next fetch address.
  logic [31:0] exp_pc;
  logic [31:0] exp_faddr;
  logic        hold_q;
  logic [31:0] held_instr, held_pc;
  logic        last_frdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
    if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_word();
    return mem[a];
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a & 32'hFFFF_FFFC);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock: drive at negedge, check, then advance to the next negedge.
  task automatic step(input logic v, input logic r, input logic rd, input logic [31:0] rpc);
    logic [15:0] h0;
    logic [31:0] ei;
    logic        ec;
    if (hold_q) begin
      check("hold_valid", 32'(bus.instr_valid_o), 32'd1);
      check("hold_instr", bus.instr_o, held_instr);
      check("hold_pc", bus.instr_pc_o, held_pc);
    end
    bus.fetch_valid_i = v;
    bus.fetch_word_i  = v ? mem_rd(exp_faddr) : $urandom;
    bus.instr_ready_i = r;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    #1;
    check("fetch_addr", bus.fetch_addr_o, exp_faddr);
    last_frdy = bus.fetch_ready_o;
    if (rd) check("redir_frdy", 32'(bus.fetch_ready_o), 32'd0);
    if (bus.instr_valid_o && r) begin
      h0 = hw(exp_pc);
      ec = (h0[1:0] != 2'b11);
      ei = ec ? {16'h0000, h0} : {hw(exp_pc + 32'd2), h0};
      check("instr", bus.instr_o, ei);
      check("instr_pc", bus.instr_pc_o, exp_pc);
      check("instr_c", 32'(bus.instr_compressed_o), 32'(ec));
      exp_pc = exp_pc + (ec ? 32'd2 : 32'd4);
      n_out++;
    end
    hold_q     = bus.instr_valid_o && !r && !rd;
    held_instr = bus.instr_o;
    held_pc    = bus.instr_pc_o;
    if (v && bus.fetch_ready_o) exp_faddr = exp_faddr + 32'd4;
    if (rd) begin
      exp_pc    = rpc & 32'hFFFF_FFFE;
      exp_faddr = rpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] pc, input logic c);
    check({tag, "_valid"}, 32'(bus.instr_valid_o), 32'(v));
    if (v) begin
      check({tag, "_instr"}, bus.instr_o, i);
      check({tag, "_pc"}, bus.instr_pc_o, pc);
      check({tag, "_c"}, 32'(bus.instr_compressed_o), 32'(c));
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    step(1'b0, 1'b0, 1'b1, pc);
    mem.delete();
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_word_i  = 32'h0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    exp_pc = 32'h0; exp_faddr = 32'h0; hold_q = 1'b0; last_frdy = 1'b0;
    held_instr = 32'h0; held_pc = 32'h0;
    #1;
    check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    check("rst_instr", bus.instr_o, 32'h0);
    check("rst_pc", bus.instr_pc_o, 32'h0);
    check("rst_faddr", bus.fetch_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single 32-bit instruction at boot.
    mem[32'h0] = 32'h00A00093;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t1", 1'b1, 32'h00A00093, 32'h0, 1'b0);
    check("t1_faddr", bus.fetch_addr_o, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Two compressed instructions from one word.
    restart(32'h0);
    mem[32'h0] = 32'h45050505;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t2a", 1'b1, 32'h00000505, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t2_frdy", 32'(last_frdy), 32'd0);
    expect_out("t2b", 1'b1, 32'h00004505, 32'h2, 1'b1);

    // Straddling 32-bit instruction between two compressed ones.
    restart(32'h0);
    mem[32'h0] = 32'h00930505;
    mem[32'h4] = 32'h050500A0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t3a", 1'b1, 32'h00000505, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t3b", 1'b1, 32'h00A00093, 32'h2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_frdy", 32'(last_frdy), 32'd0);
    expect_out("t3c", 1'b1, 32'h00000505, 32'h6, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("t3d", 1'b0, 32'h0, 32'h0, 1'b0);
    check("t3_faddr", bus.fetch_addr_o, 32'h8);

    // Downstream stall for three cycles with a word waiting upstream.
    restart(32'h0);
    mem[32'h0] = 32'h00A00093;
    mem[32'h4] = 32'h00A00113;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("t4_frdy", 32'(last_frdy), 32'd0);
    end
    expect_out("t4a", 1'b1, 32'h00A00093, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t4b", 1'b1, 32'h00A00113, 32'h4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect to a misaligned target while an output is pending.
    restart(32'h0);
    mem[32'h0]   = 32'h00A00093;
    mem[32'h100] = 32'h45050505;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h102);
    expect_out("t5a", 1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_faddr", bus.fetch_addr_o, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t5b", 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("t5c", 1'b1, 32'h00004505, 32'h102, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset while the first half of a straddling instruction is buffered.
    restart(32'h0);
    mem[32'h0] = 32'h00930505;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    expect_out("t6_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    check("t6_rst_instr", bus.instr_o, 32'h0);
    check("t6_rst_faddr", bus.fetch_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0; exp_faddr = 32'h0; hold_q = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("t6a", 1'b1, 32'h00000505, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic with occasional redirects, including near wrap.
    restart(32'h0000_1000);
    n_out = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        v, r, rd;
      logic [31:0] rpc;
      v   = ($urandom_range(99, 0) < 75);
      r   = ($urandom_range(99, 0) < 70);
      rd  = ($urandom_range(99, 0) < 2);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                        : ($urandom & 32'h0000_FFFF);
      step(v, r, rd, rpc);
    end
    check("rand_progress", 32'(n_out > 1000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_fetch_aligner.md
Name: rvc_fetch_aligner

Overview:
- Sits between the fetch stage and rvc_expander.
- Accepts in-order, word-aligned 32-bit fetch words and splits them into discrete instructions: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Each instruction is presented with its PC over a valid/ready handshake. Compressed instructions are zero-extended so rvc_expander can consume instr_o directly.
- Handles control-flow redirects to halfword-aligned targets.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-low
- fetch_addr_o  output  32  word-aligned address of the next word the block expects
- fetch_valid_i  input  1  fetch_word_i holds the word at fetch_addr_o
- fetch_word_i  input  32  fetched word; little-endian halfwords
- fetch_ready_o  output  1  word accepted this cycle when fetch_valid_i is also high
- redirect_i  input  1  flush and restart at redirect_pc_i
- redirect_pc_i  input  32  new PC; bit 0 ignored
- instr_valid_o  output  1  instr_o, instr_pc_o and instr_compressed_o are valid
- instr_o  output  32  32-bit instruction, or {16'h0000, halfword} for a compressed instruction
- instr_pc_o  output  32  PC of instr_o
- instr_compressed_o  output  1  1 when instr_o is a 16-bit instruction
- instr_ready_i  input  1  downstream accepts instr_o this cycle

Behaviour:
- Reset:
  - Applied asynchronously when rst_i = 0.
  - All instr_* outputs = 0.
  - fetch_addr_o = {BOOT_ADDR[31:2], 2'b00}.
  - pc_r = {BOOT_ADDR[31:1], 1'b0}.
  - State = S_SKIP if BOOT_ADDR[1] = 1, else S_ALIGNED.
  - Halfword buffer hb_r = 0.
- Output slot: a single output register. It may load when slot_free = !instr_valid_o || instr_ready_i. Output holds stable while instr_valid_o && !instr_ready_i.
- Word accept: fetch_valid_i && fetch_ready_o. On accept, fetch_addr_o += 4.
- A halfword is 32-bit iff [1:0] == 2'b11, otherwise compressed.
- S_ALIGNED (nothing buffered):
  - fetch_ready_o = slot_free.
  - On accept with low half compressed: output {16'h0, word[15:0]} at pc_r, compressed = 1; hb_r <= word[31:16]; go to S_HALF; pc_r += 2.
  - On accept with a 32-bit low half: output the word at pc_r, compressed = 0; pc_r += 4; stay in S_ALIGNED.
- S_HALF (hb_r holds the next instruction's first halfword):
  - If hb_r is compressed: fetch_ready_o = 0. When slot_free, output {16'h0, hb_r}, compressed = 1; pc_r += 2; go to S_ALIGNED.
  - If hb_r is 32-bit: fetch_ready_o = slot_free. On accept, output {word[15:0], hb_r}, compressed = 0; pc_r += 4; hb_r <= word[31:16]; stay in S_HALF.
- S_SKIP (misaligned start):
  - fetch_ready_o = 1.
  - On accept, discard word[15:0]; hb_r <= word[31:16]; go to S_HALF; no output.
- Latency: an instruction appears on the outputs one cycle after the accept or load edge. Sustained throughput is one instruction per cycle when instr_ready_i = 1.
- Redirect (highest priority, synchronous):
  - fetch_ready_o is forced to 0 in the redirect_i cycle; any presented word is not consumed.
  - Next cycle: instr_valid_o = 0, including when an output was pending.
  - pc_r = {redirect_pc_i[31:1], 1'b0}.
  - fetch_addr_o = {redirect_pc_i[31:2], 2'b00}.
  - State = S_SKIP if redirect_pc_i[1] = 1, else S_ALIGNED.
  - hb_r is dropped.
- Simultaneous instr_ready_i and a new load: the old output retires and the new one loads on the same edge; no bubble.
- Upstream must hold fetch_word_i and fetch_valid_i until accepted.
- All-zero halfword: passed as a compressed instruction; illegal-instruction detection happens downstream.
- PC and fetch address arithmetic are modulo 2^32 and wrap silently.
- Reset mid-operation: buffered halfword and pending output discarded immediately.

Test Plan:
- BOOT_ADDR = 0, word 0x00A00093 -> next cycle instr_valid_o = 1, instr_o = 0x00A00093, instr_pc_o = 0x0, instr_compressed_o = 0; fetch_addr_o = 0x4.
- Word 0x45050505 at 0x0, instr_ready_i = 1:
  - Response: 0x00000505 @0x0 then 0x00004505 @0x2, both compressed = 1.
  - fetch_ready_o = 0 during the second cycle.
- Words 0x00930505 then 0x050500A0:
  - Response, in order: 0x00000505 @0x0, 0x00A00093 @0x2, 0x00000505 @0x6.
  - Then the block waits for the word at 0x8.
- Hold instr_ready_i = 0 for 3 cycles while an output is pending -> instr_o and instr_pc_o stable, fetch_ready_o = 0, no word lost; release -> the sequence continues in order.
- Redirect to 0x102 with an output pending:
  - Next cycle: instr_valid_o = 0, fetch_addr_o = 0x100.
  - Then word 0x45050505 -> only 0x00004505 @0x102.
- Assert rst_i = 0 while hb_r holds the upper half of a straddling instruction -> outputs 0 immediately; after release, the first output is the instruction at BOOT_ADDR.
